// File: rtl/alu_serial_pkg.sv
// alu_serial_pkg
// Shared definitions for the bit-serial ALU sequencer:
//   - opcode values accepted on alu_serial_ctrl.op
//   - 2-bit operation select understood by alu_bit_slice
//   - sequencer state encoding
package alu_serial_pkg;

   // Requester-facing opcodes (3'b110 / 3'b111 are illegal)
   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_NOR  = 3'b100;
   localparam logic [2:0] OP_NAND = 3'b101;

   // Slice operation select
   localparam logic [1:0] SLICE_AND  = 2'b00;
   localparam logic [1:0] SLICE_OR   = 2'b01;
   localparam logic [1:0] SLICE_ADD  = 2'b10;
   localparam logic [1:0] SLICE_NONE = 2'b11;  // slice result forced to 0

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/alu_serial_ctrl_slice.sv
// alu_bit_slice
// Combinational 1-bit ALU slice with optional input inversion.
// Ports:
//   a, b        operand bits
//   ainvert     invert a before use
//   binvert     invert b before use
//   carry_in    carry into the adder
//   operation   00 AND, 01 OR, 10 ADD (sum), 11 constant 0
//   result      selected result bit
//   carry_out   adder carry out (always computed, used only for ADD/SUB)
module alu_bit_slice
   import alu_serial_pkg::*;
(
   input  logic       a,
   input  logic       b,
   input  logic       ainvert,
   input  logic       binvert,
   input  logic       carry_in,
   input  logic [1:0] operation,
   output logic       result,
   output logic       carry_out
);

   logic a_eff;
   logic b_eff;

   assign a_eff     = a ^ ainvert;
   assign b_eff     = b ^ binvert;
   assign carry_out = (a_eff & b_eff) | (a_eff & carry_in) | (b_eff & carry_in);

   always_comb begin
      result = 1'b0;
      case (operation)
         SLICE_AND: result = a_eff & b_eff;
         SLICE_OR:  result = a_eff | b_eff;
         SLICE_ADD: result = a_eff ^ b_eff ^ carry_in;
         default:   result = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl
// Bit-serial WIDTH-bit ALU built around one alu_bit_slice. Operands are
// captured on an accepted start and processed LSB first, one bit per clock.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   start       request pulse (only honoured in IDLE)
//   op, a, b    opcode and operands, captured with start
//   busy        high while bits are being processed
//   done        one-cycle completion pulse
//   result      result, held until the next accepted start
//   carry_out   final carry (ADD/SUB only)
//   overflow    signed overflow (ADD/SUB only)
//   zero        result == 0, valid from done
module alu_serial_ctrl
   import alu_serial_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero
);

   // One guard bit above what is needed to count to WIDTH-1
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [2:0]       op_q, op_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             carry_out_q, carry_out_d;
   logic             overflow_q, overflow_d;
   logic             zero_q, zero_d;

   // Slice control decoded from the captured opcode
   logic       ainvert;
   logic       binvert;
   logic [1:0] slice_op;
   logic       is_arith;
   logic       slice_res;
   logic       slice_cout;

   always_comb begin
      ainvert  = 1'b0;
      binvert  = 1'b0;
      slice_op = SLICE_NONE;
      is_arith = 1'b0;
      case (op_q)
         OP_AND:  slice_op = SLICE_AND;
         OP_OR:   slice_op = SLICE_OR;
         OP_ADD: begin
            slice_op = SLICE_ADD;
            is_arith = 1'b1;
         end
         OP_SUB: begin
            slice_op = SLICE_ADD;
            binvert  = 1'b1;
            is_arith = 1'b1;
         end
         // De Morgan: ~a & ~b = ~(a|b), ~a | ~b = ~(a&b)
         OP_NOR: begin
            slice_op = SLICE_AND;
            ainvert  = 1'b1;
            binvert  = 1'b1;
         end
         OP_NAND: begin
            slice_op = SLICE_OR;
            ainvert  = 1'b1;
            binvert  = 1'b1;
         end
         default: slice_op = SLICE_NONE;
      endcase
   end

   alu_bit_slice u_slice (
      .a         (a_sh_q[0]),
      .b         (b_sh_q[0]),
      .ainvert   (ainvert),
      .binvert   (binvert),
      .carry_in  (carry_q),
      .operation (slice_op),
      .result    (slice_res),
      .carry_out (slice_cout)
   );

   always_comb begin
      state_d     = state_q;
      a_sh_d      = a_sh_q;
      b_sh_d      = b_sh_q;
      result_d    = result_q;
      op_d        = op_q;
      cnt_d       = cnt_q;
      carry_d     = carry_q;
      carry_out_d = carry_out_q;
      overflow_d  = overflow_q;
      zero_d      = zero_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = RUN;
               a_sh_d      = a;
               b_sh_d      = b;
               op_d        = op;
               cnt_d       = '0;
               result_d    = '0;
               carry_out_d = 1'b0;
               overflow_d  = 1'b0;
               zero_d      = 1'b0;
               // SUB is A + ~B + 1: the +1 enters as the initial carry
               carry_d     = (op == OP_SUB);
            end
         end
         RUN: begin
            // Shift in from the MSB side so bit 0 lands in the LSB after WIDTH steps
            result_d = {slice_res, result_q[WIDTH-1:1]};
            if (is_arith) begin
               carry_d = slice_cout;
            end
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d     = DONE;
               // During the MSB step carry_q still holds the carry into the MSB
               carry_out_d = is_arith & slice_cout;
               overflow_d  = is_arith & (carry_q ^ slice_cout);
               zero_d      = ~|result_d;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         result_q    <= '0;
         op_q        <= '0;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
         zero_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_sh_q      <= a_sh_d;
         b_sh_q      <= b_sh_d;
         result_q    <= result_d;
         op_q        <= op_d;
         cnt_q       <= cnt_d;
         carry_q     <= carry_d;
         carry_out_q <= carry_out_d;
         overflow_q  <= overflow_d;
         zero_q      <= zero_d;
      end
   end

   assign busy      = (state_q == RUN);
   assign done      = (state_q == DONE);
   assign result    = result_q;
   assign carry_out = carry_out_q;
   assign overflow  = overflow_q;
   assign zero      = zero_q;

endmodule
